// File: rtl/instr_decode_ctrl_pkg.sv
// Shared opcode, state, field and ALU-code definitions for the
// instruction decode/control unit.
package instr_decode_ctrl_pkg;

  localparam logic [2:0] RA    = 3'd0;
  localparam logic [2:0] RB    = 3'd1;
  localparam logic [2:0] RADD  = 3'd2;
  localparam logic [2:0] RSUB  = 3'd3;
  localparam logic [2:0] RMULL = 3'd4;

  localparam logic [1:0] REG    = 2'd0;
  localparam logic [1:0] SW_7_0 = 2'd1;
  localparam logic [1:0] SW_8   = 2'd2;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_MOV   = 4'h3,
    OP_MUL   = 4'h4,
    OP_ADDI  = 4'h5,
    OP_LDI   = 4'h6,
    OP_IN    = 4'h7,
    OP_INB   = 4'h8,
    OP_BZ    = 4'h9,
    OP_BNZ   = 4'hA,
    OP_BN    = 4'hB,
    OP_JMP   = 4'hC,
    OP_ILL_D = 4'hD,
    OP_ILL_E = 4'hE,
    OP_HALT  = 4'hF
  } op_t;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [2:0] func;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       imm;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wr;
  } ctrl_t;

  function automatic logic is_alu(op_t op);
    return (op >= OP_ADD) && (op <= OP_INB);
  endfunction

  function automatic ctrl_t decode_ctrl(logic [15:0] ins);
    ctrl_t c;
    op_t   op;
    op      = op_t'(ins[OP_HI:OP_LO]);
    c.func  = RA;
    c.a_sel = REG;
    c.b_sel = REG;
    c.imm   = 1'b0;
    c.ra    = ins[RA_HI:RA_LO];
    c.rb    = ins[RB_HI:RB_LO];
    c.wr    = ins[RD_HI:RD_LO];
    unique case (1'b1)
      (op == OP_ADD): c.func = RADD;
      (op == OP_SUB): c.func = RSUB;
      (op == OP_MOV): c.func = RA;
      (op == OP_MUL): c.func = RMULL;
      (op == OP_ADDI): begin
        c.func = RADD;
        c.ra   = ins[RD_HI:RD_LO];
        c.imm  = 1'b1;
      end
      (op == OP_LDI): begin
        c.func = RB;
        c.imm  = 1'b1;
      end
      (op == OP_IN):  c.a_sel = SW_7_0;
      (op == OP_INB): c.a_sel = SW_8;
      default: c.func = RA;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_decode_ctrl_pc_unit.sv
// Program counter: sequential increment or relative branch,
// both wrapping modulo 2**PC_W.
module instr_decode_ctrl_pc_unit #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            jump,
  input  logic [7:0]      offset,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_tgt;

  assign pc_seq = pc + PC_W'(1);
  assign pc_tgt = pc_seq + PC_W'(signed'(offset));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (jump) begin
      pc <= pc_tgt;
    end else if (inc) begin
      pc <= pc_seq;
    end
  end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller
// driving the ALU, register file and PC.
module instr_decode_ctrl
  import instr_decode_ctrl_pkg::*;
#(
  parameter int n    = 8,
  parameter int PC_W = 8
) (
  input  logic            Clock,
  input  logic            nReset,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  input  logic [15:0]     instr_data,
  output logic [2:0]      func,
  output logic [1:0]      a_sel,
  output logic [1:0]      b_sel,
  output logic            imm,
  output logic [7:0]      immediate,
  output logic [2:0]      ra_addr,
  output logic [2:0]      rb_addr,
  output logic [2:0]      wr_addr,
  output logic            wr_en,
  input  logic [3:0]      flags_in,
  output logic [3:0]      flags,
  output logic            halted,
  output logic            illegal
);

  state_t          state;
  logic [15:0]     instr;
  op_t             op;
  ctrl_t           ctl_q;
  logic [n-1:0]    imm_val;
  logic            taken;
  logic            pc_inc;
  logic            pc_jump;
  logic [PC_W-1:0] pc;

  assign op = op_t'(instr[OP_HI:OP_LO]);

  // Branches only ever look at the registered flags.
  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (op == OP_BZ):  taken = flags[1];
      (op == OP_BNZ): taken = !flags[1];
      (op == OP_BN):  taken = flags[2];
      (op == OP_JMP): taken = 1'b1;
      default:        taken = 1'b0;
    endcase
  end

  assign pc_jump = (state == S_EXEC) && taken;
  assign pc_inc  = (state == S_WB)
                || ((state == S_EXEC)
                    && !is_alu(op)
                    && (op != OP_HALT)
                    && !taken);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
      instr <= '0;
    end else begin
      unique case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH: begin
          if (instr_valid) begin
            instr <= instr_data;
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (op == OP_HALT) begin
            state <= S_HALT;
          end else if (is_alu(op)) begin
            state <= S_WB;
          end else begin
            state <= S_FETCH;
          end
        end
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ctl_q   <= '{RA, REG, REG, 1'b0, 3'd0, 3'd0, 3'd0};
      imm_val <= '0;
    end else if (state == S_DECODE) begin
      ctl_q   <= decode_ctrl(instr);
      imm_val <= n'(instr[IMM_HI:IMM_LO]);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      flags <= '0;
    end else if (state == S_WB) begin
      flags <= flags_in;
    end
  end

  instr_decode_ctrl_pc_unit #(
    .PC_W (PC_W)
  ) u_pc (
    .clk    (Clock),
    .rst_n  (nReset),
    .inc    (pc_inc),
    .jump   (pc_jump),
    .offset (instr[IMM_HI:IMM_LO]),
    .pc     (pc)
  );

  assign instr_req  = (state == S_FETCH);
  assign instr_addr = pc;
  assign wr_en      = (state == S_WB);
  assign halted     = (state == S_HALT);
  assign illegal    = (state == S_EXEC)
                   && ((op == OP_ILL_D) || (op == OP_ILL_E));

  assign func      = ctl_q.func;
  assign a_sel     = ctl_q.a_sel;
  assign b_sel     = ctl_q.b_sel;
  assign imm       = ctl_q.imm;
  assign ra_addr   = ctl_q.ra;
  assign rb_addr   = ctl_q.rb;
  assign wr_addr   = ctl_q.wr;
  assign immediate = 8'(imm_val);

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Randomized bench for instr_decode_ctrl against an
// instruction-level reference model.
module tb_instr_decode_ctrl;
  import instr_decode_ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = '0;
  logic [2:0]  func;
  logic [1:0]  a_sel;
  logic [1:0]  b_sel;
  logic        imm;
  logic [7:0]  immediate;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [2:0]  wr_addr;
  logic        wr_en;
  logic [3:0]  flags_in = '0;
  logic [3:0]  flags;
  logic        halted;
  logic        illegal;

  int total = 0;
  int bad = 0;

  int         m_pc;
  logic [3:0] m_flags;

  always #5 Clock = ~Clock;

  instr_decode_ctrl #(
    .n    (8),
    .PC_W (8)
  ) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .func        (func),
    .a_sel       (a_sel),
    .b_sel       (b_sel),
    .imm         (imm),
    .immediate   (immediate),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .flags_in    (flags_in),
    .flags       (flags),
    .halted      (halted),
    .illegal     (illegal)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    nReset      = 1'b0;
    instr_valid = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_req", instr_req, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_halt", halted, 0);
    chk("rst_pc", instr_addr, 0);
    chk("rst_flags", flags, 0);
    chk("rst_func", func, RA);
    chk("rst_sel", {a_sel, b_sel}, {REG, REG});
    chk("rst_imm", {imm, immediate}, 0);
    chk("rst_addr", {ra_addr, rb_addr, wr_addr}, 0);
    nReset  = 1'b1;
    m_pc    = 0;
    m_flags = 4'h0;
    chk("idle_req", instr_req, 0);
    @(negedge Clock);
    chk("fetch_req", instr_req, 1);
    chk("fetch_addr0", instr_addr, 0);
  endtask

  task automatic run_instr(input logic [15:0] ins,
                           input logic [3:0] fi,
                           input int dly);
    int         op;
    int         k;
    int         lat;
    int         nwr;
    int         nill;
    int         off;
    bit         alu;
    bit         tk;
    logic [2:0] e_func;
    logic [1:0] e_asel;
    logic       e_imm;
    logic [2:0] e_ra;
    logic [2:0] c_func;
    logic [1:0] c_asel;
    logic [1:0] c_bsel;
    logic       c_imm;
    logic [7:0] c_immv;
    logic [2:0] c_ra;
    logic [2:0] c_rb;
    logic [2:0] c_wr;
    op  = int'(ins[15:12]);
    off = $signed(ins[7:0]);
    k = 0;
    while (!instr_req && k < 20) begin
      @(negedge Clock);
      k++;
    end
    chk("req_wait", instr_req, 1);
    chk("fetch_addr", instr_addr, m_pc);
    flags_in = fi;
    for (int i = 0; i < dly; i++) begin
      instr_valid = 1'b0;
      instr_data  = 16'($urandom);
      @(negedge Clock);
      chk("req_hold", instr_req, 1);
      chk("addr_hold", instr_addr, m_pc);
    end
    instr_valid = 1'b1;
    instr_data  = ins;
    @(negedge Clock);
    instr_valid = 1'b0;
    instr_data  = 16'($urandom);
    lat  = 1;
    nwr  = 0;
    nill = 0;
    {c_func, c_asel, c_bsel, c_imm} = '0;
    {c_immv, c_ra, c_rb, c_wr} = '0;
    while (!instr_req && !halted && lat < 20) begin
      if (wr_en) begin
        nwr++;
        c_func = func;
        c_asel = a_sel;
        c_bsel = b_sel;
        c_imm  = imm;
        c_immv = immediate;
        c_ra   = ra_addr;
        c_rb   = rb_addr;
        c_wr   = wr_addr;
      end
      if (illegal) nill++;
      @(negedge Clock);
      lat++;
    end

    alu    = (op >= 1) && (op <= 8);
    e_func = RA;
    e_asel = REG;
    e_imm  = 1'b0;
    e_ra   = ins[8:6];
    case (op)
      1: e_func = RADD;
      2: e_func = RSUB;
      4: e_func = RMULL;
      5: begin
        e_func = RADD;
        e_imm  = 1'b1;
        e_ra   = ins[11:9];
      end
      6: begin
        e_func = RB;
        e_imm  = 1'b1;
      end
      7: e_asel = SW_7_0;
      8: e_asel = SW_8;
      default: e_func = RA;
    endcase
    case (op)
      9:  tk = m_flags[1];
      10: tk = !m_flags[1];
      11: tk = m_flags[2];
      12: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    if (op != 15) begin
      if (tk) m_pc = (m_pc + 1 + off) & 255;
      else    m_pc = (m_pc + 1) & 255;
    end
    if (alu) m_flags = fi;

    chk("latency", lat, alu ? 4 : 3);
    chk("wr_cnt", nwr, alu ? 1 : 0);
    chk("ill_cnt", nill, (op == 13 || op == 14) ? 1 : 0);
    chk("halted", halted, (op == 15) ? 1 : 0);
    chk("pc", instr_addr, m_pc);
    chk("flags", flags, m_flags);
    if (alu) begin
      chk("func", c_func, e_func);
      chk("a_sel", c_asel, e_asel);
      chk("b_sel", c_bsel, REG);
      chk("imm", c_imm, e_imm);
      chk("wr_addr", c_wr, ins[11:9]);
      if (e_imm) chk("immediate", c_immv, ins[7:0]);
      if (op <= 5) chk("ra_addr", c_ra, e_ra);
      if (op == 1 || op == 2 || op == 4)
        chk("rb_addr", c_rb, ins[5:3]);
    end
  endtask

  task automatic reset_in_wb();
    int k;
    k = 0;
    while (!instr_req && k < 20) begin
      @(negedge Clock);
      k++;
    end
    flags_in    = 4'hF;
    instr_valid = 1'b1;
    instr_data  = 16'h1650;
    @(negedge Clock);
    instr_valid = 1'b0;
    repeat (2) @(negedge Clock);
    chk("wb_reached", wr_en, 1);
    #2 nReset = 1'b0;
    #1;
    chk("rst_wb_wr", wr_en, 0);
    chk("rst_wb_pc", instr_addr, 0);
    chk("rst_wb_flags", flags, 0);
    @(negedge Clock);
    chk("rst_wb_nowr", wr_en, 0);
    nReset  = 1'b1;
    m_pc    = 0;
    m_flags = 4'h0;
    chk("rst_wb_idle", instr_req, 0);
    @(negedge Clock);
    chk("rst_wb_fetch", instr_req, 1);
    chk("rst_wb_addr", instr_addr, 0);
  endtask

  initial begin
    logic [15:0] ins;
    int          op;
    do_reset();

    run_instr(16'h6205, 4'h0, 0);
    run_instr(16'h1650, 4'b0011, 0);
    run_instr(16'h5001, 4'b0010, 0);
    run_instr(16'hC00C, 4'h0, 0);
    run_instr(16'h9004, 4'h0, 0);
    run_instr(16'h5001, 4'b0000, 0);
    run_instr(16'h9004, 4'h0, 0);
    run_instr(16'hC0E7, 4'h0, 0);
    run_instr(16'h5E01, 4'b0100, 0);
    run_instr(16'hC0FE, 4'h0, 0);
    run_instr(16'hD000, 4'hF, 0);
    run_instr(16'hE123, 4'hF, 1);
    run_instr(16'h1650, 4'b1001, 5);

    for (int i = 0; i < 200; i++) begin
      op  = $urandom_range(0, 14);
      ins = {4'(op), 12'($urandom)};
      run_instr(ins, 4'($urandom),
                ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2));
    end

    reset_in_wb();
    run_instr(16'h6205, 4'h6, 0);
    run_instr(16'hF000, 4'hA, 0);
    for (int i = 0; i < 20; i++) begin
      instr_valid = 1'($urandom);
      @(negedge Clock);
      chk("halt_req", instr_req, 0);
      chk("halt_wr", wr_en, 0);
      chk("halt_pc", instr_addr, m_pc);
    end
    chk("halt_hold", halted, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
